// File: rtl/cpu_pkg.sv
// Shared types and defaults for the 8-bit processor front end: fetch FSM
// states, instruction/offset widths and the PC reset/step defaults.
package cpu_pkg;

  localparam int INSTR_W  = 32;
  localparam int OFFSET_W = 8;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EXEC  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_target_adder.sv
// Combinational next-PC arithmetic: sequential successor and the
// jump/branch target, which is relative to the successor (word offset).
module pc_target_adder
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0]         PC,
  input  logic [OFFSET_W-1:0] OFFSET_8BIT,
  output logic [31:0]         PC_NEXT,
  output logic [31:0]         PC_TARGET
);

  logic [31:0] byte_offset;

  assign byte_offset = {{22{OFFSET_8BIT[7]}}, OFFSET_8BIT, 2'b00};
  assign PC_NEXT     = PC + PC_STEP;
  assign PC_TARGET   = PC_NEXT + byte_offset;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over the busywait handshake,
// holds the instruction for the decoder and steps the PC when execution ends.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                STALL,
  input  logic                JUMP,
  input  logic                BRANCH,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET_8BIT,
  output logic                IMEM_READ,
  output logic [31:0]         IMEM_ADDRESS,
  input  logic [INSTR_W-1:0]  IMEM_READDATA,
  input  logic                IMEM_BUSYWAIT,
  output logic [INSTR_W-1:0]  INSTRUCTION,
  output logic [31:0]         PC,
  output logic                INSTR_VALID,
  output logic [1:0]          STATE_DBG
);

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [31:0]          pc_next, pc_target;
  logic                 taken;

  pc_target_adder #(
    .PC_STEP (PC_STEP)
  ) u_pc_target_adder (
    .PC          (pc_q),
    .OFFSET_8BIT (OFFSET_8BIT),
    .PC_NEXT     (pc_next),
    .PC_TARGET   (pc_target)
  );

  assign taken = JUMP | (BRANCH & ZERO);

  // Handshake: IMEM_READ is the request valid and !IMEM_BUSYWAIT the ready;
  // a word transfers on any rising edge where both are high, and the
  // request and address stay constant until that edge.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH, ST_WAIT: begin
        if (!IMEM_BUSYWAIT) begin
          instr_d = IMEM_READDATA;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_EXEC: begin
        if (!STALL) begin
          pc_d    = taken ? pc_target : pc_next;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RESET;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Outputs decode registered state only, so reset drops IMEM_READ at once.
  assign IMEM_READ    = (state_q == ST_FETCH) || (state_q == ST_WAIT);
  assign INSTR_VALID  = (state_q == ST_EXEC);
  assign IMEM_ADDRESS = pc_q;
  assign PC           = pc_q;
  assign INSTRUCTION  = instr_q;
  assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed and random instruction
// transactions checked against a program-counter reference model.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL, JUMP, BRANCH, ZERO;
  logic [7:0]  OFFSET_8BIT;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic        INSTR_VALID;
  logic [1:0]  state_dbg;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [31:0] mem_key;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  instruction_fetch_unit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .STALL         (STALL),
    .JUMP          (JUMP),
    .BRANCH        (BRANCH),
    .ZERO          (ZERO),
    .OFFSET_8BIT   (OFFSET_8BIT),
    .IMEM_READ     (IMEM_READ),
    .IMEM_ADDRESS  (IMEM_ADDRESS),
    .IMEM_READDATA (IMEM_READDATA),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .INSTRUCTION   (INSTRUCTION),
    .PC            (PC),
    .INSTR_VALID   (INSTR_VALID),
    .STATE_DBG     (state_dbg)
  );

  // Clock and watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ mem_key;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive_junk();
    JUMP        = 1'($urandom_range(0, 1));
    BRANCH      = 1'($urandom_range(0, 1));
    ZERO        = 1'($urandom_range(0, 1));
    OFFSET_8BIT = 8'($urandom);
    STALL       = 1'($urandom_range(0, 1));
  endtask

  // Reference model: the next PC is the sequential successor, or that plus a
  // signed word offset when the instruction jumps or branches on zero.
  function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic j,
                                                input logic b, input logic z,
                                                input logic [7:0] off);
    int signed   off_bytes;
    logic [31:0] succ;
    off_bytes = int'($signed(off)) * 4;
    succ      = pc + 32'd4;
    if (j || (b && z)) return succ + 32'(off_bytes);
    return succ;
  endfunction

  // One full instruction: FETCH, `busy` busywait edges, EXEC with `stalls`
  // stall cycles, then the controls that decide the next PC.
  task automatic do_instr(input int busy, input int stalls, input logic j, input logic b,
                          input logic z, input logic [7:0] off, input logic hold_jump);
    chk("fetch_read",  32'(IMEM_READ), 32'd1);
    chk("fetch_addr",  IMEM_ADDRESS, exp_pc);
    chk("fetch_valid", 32'(INSTR_VALID), 32'd0);
    chk("fetch_instr_hold", INSTRUCTION, exp_instr);
    drive_junk();
    IMEM_BUSYWAIT = (busy > 0);
    IMEM_READDATA = (busy > 0) ? $urandom : mem_word(exp_pc);
    tick();
    for (int k = 1; k <= busy; k++) begin
      chk("wait_read",  32'(IMEM_READ), 32'd1);
      chk("wait_addr",  IMEM_ADDRESS, exp_pc);
      chk("wait_valid", 32'(INSTR_VALID), 32'd0);
      chk("wait_instr_hold", INSTRUCTION, exp_instr);
      drive_junk();
      IMEM_BUSYWAIT = (k < busy);
      IMEM_READDATA = (k < busy) ? $urandom : mem_word(exp_pc);
      tick();
    end
    exp_instr     = mem_word(exp_pc);
    IMEM_BUSYWAIT = 1'($urandom_range(0, 1));
    IMEM_READDATA = $urandom;
    for (int s = 0; s <= stalls; s++) begin
      chk("exec_valid", 32'(INSTR_VALID), 32'd1);
      chk("exec_read",  32'(IMEM_READ), 32'd0);
      chk("exec_pc",    PC, exp_pc);
      chk("exec_instr", INSTRUCTION, exp_instr);
      if (s < stalls) begin
        drive_junk();
        STALL = 1'b1;
        if (hold_jump) begin
          JUMP        = 1'b1;
          OFFSET_8BIT = off;
        end
      end else begin
        STALL       = 1'b0;
        JUMP        = j;
        BRANCH      = b;
        ZERO        = z;
        OFFSET_8BIT = off;
      end
      tick();
    end
    exp_pc = model_next_pc(exp_pc, j, b, z, off);
  endtask

  initial begin
    mem_key       = $urandom;
    RESET         = 1'b0;
    STALL         = 1'b0;
    JUMP          = 1'b0;
    BRANCH        = 1'b0;
    ZERO          = 1'b0;
    OFFSET_8BIT   = 8'h00;
    IMEM_READDATA = 32'h0;
    IMEM_BUSYWAIT = 1'b0;
    exp_pc        = 32'h0;
    exp_instr     = 32'h0;

    repeat (3) @(negedge CLK);
    chk("reset_read",  32'(IMEM_READ), 32'd0);
    chk("reset_pc",    PC, 32'h0);
    chk("reset_instr", INSTRUCTION, 32'h0);
    chk("reset_valid", 32'(INSTR_VALID), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    RESET = 1'b1;
    chk("idle_read", 32'(IMEM_READ), 32'd0);
    tick();

    // Sequential hits at 0, 4, then a jump at 8 to 0x14.
    do_instr(0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_instr(0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_instr(0, 0, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0);
    chk("jump_fwd_target", IMEM_ADDRESS, 32'h14);
    do_instr(0, 0, 1'b1, 1'b0, 1'b0, 8'hFC, 1'b0);
    do_instr(0, 0, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b0);
    chk("jump_back_target", IMEM_ADDRESS, 32'h04);
    do_instr(0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_instr(0, 0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0);
    chk("branch_not_taken", IMEM_ADDRESS, 32'h0C);
    do_instr(0, 0, 1'b1, 1'b1, 1'b0, 8'hFE, 1'b0);
    chk("jump_and_branch", IMEM_ADDRESS, 32'h08);
    do_instr(0, 0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
    chk("branch_taken", IMEM_ADDRESS, 32'h10);

    // Miss at 0x10 with three busy edges, then a stall with a held jump.
    do_instr(3, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_instr(0, 2, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
    chk("stall_jump_once", IMEM_ADDRESS, 32'h1C);

    // Reach 0xFFFF_FFFC and wrap.
    do_instr(0, 0, 1'b1, 1'b0, 1'b0, 8'hF8, 1'b0);
    do_instr(0, 0, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b0);
    chk("neg_target", IMEM_ADDRESS, 32'hFFFF_FFFC);
    do_instr(1, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("wrap_target", IMEM_ADDRESS, 32'h0);
    do_instr(0, 0, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0);
    chk("min_offset", IMEM_ADDRESS, 32'hFFFF_FE04);

    for (int n = 0; n < 40; n++) begin
      do_instr($urandom_range(0, 3), $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end

    // Reset asserted mid-cycle while a read is outstanding in WAIT.
    chk("pre_reset_read", 32'(IMEM_READ), 32'd1);
    IMEM_BUSYWAIT = 1'b1;
    IMEM_READDATA = $urandom;
    tick();
    chk("wait_before_reset", 32'(IMEM_READ), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("async_reset_read",  32'(IMEM_READ), 32'd0);
    chk("async_reset_pc",    PC, 32'h0);
    chk("async_reset_instr", INSTRUCTION, 32'h0);
    chk("async_reset_valid", 32'(INSTR_VALID), 32'd0);
    IMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    RESET     = 1'b1;
    exp_pc    = 32'h0;
    exp_instr = 32'h0;
    chk("post_reset_idle", 32'(IMEM_READ), 32'd0);
    tick();
    do_instr(0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_instr(2, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
